// File: rtl/ycell_cfg_pkg.sv
// Shared types and constants for the ycell configuration-chain driver.
package ycell_cfg_pkg;

    localparam int unsigned CHAIN_LEN_DEF = 48;
    localparam int unsigned WORD_W_DEF    = 8;
    localparam int unsigned STROBE_DEF    = 2;
    localparam int unsigned CLR_DEF       = 4;
    localparam int unsigned MM_W          = 16;
    localparam int unsigned STROBE_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } cfg_state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_LO   = 2'd1,
        PH_HI   = 2'd2
    } strobe_phase_e;

    function automatic logic [MM_W-1:0] sat_inc(input logic [MM_W-1:0] v);
        return (v == {MM_W{1'b1}}) ? v : v + {{(MM_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ycell_cfg_strobe.sv
// confclk phase generator: a start pulse runs one low phase then one high phase;
// a start coinciding with hi_end chains straight into the next low phase.
module ycell_cfg_strobe
    import ycell_cfg_pkg::*;
#(
    parameter int unsigned CNT_W = STROBE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] lo_w,
    input  logic [CNT_W-1:0] hi_w,
    output logic             confclk,
    output logic             lo_end,
    output logic             hi_end
);

    strobe_phase_e    phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             confclk_q, confclk_d;

    // End-of-phase flags depend only on state so the driver FSM can use them without a loop.
    assign lo_end = (phase_q == PH_LO) && (cnt_q == lo_w - CNT_W'(1));
    assign hi_end = (phase_q == PH_HI) && (cnt_q == hi_w - CNT_W'(1));

    // Phase sequencing and width counting.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_LO;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            PH_LO: begin
                if (lo_end) begin
                    phase_d = PH_HI;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PH_HI: begin
                if (hi_end) begin
                    phase_d = start ? PH_LO : PH_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        confclk_d = (phase_d == PH_HI);
    end

    // State and registered confclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            confclk_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            confclk_q <= confclk_d;
        end
    end

    assign confclk = confclk_q;

endmodule

// File: rtl/ycell_cfg_driver.sv
// Serial configuration-chain loader for a ycell column (LSB-first, programmable strobes).
// Optional chain readback compare enabled by defining YCELL_CFG_READBACK_EN.
module ycell_cfg_driver
    import ycell_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = CHAIN_LEN_DEF,
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned STROBE_LO  = STROBE_DEF,
    parameter int unsigned STROBE_HI  = STROBE_DEF,
    parameter int unsigned CLR_CYCLES = CLR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              cfg_reset,
    output logic              confclk,
    output logic              cbit,
    input  logic              cbit_tail,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [MM_W-1:0]   mismatch_cnt
);

    localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WBIT_W = $clog2(WORD_W + 1);
    localparam int unsigned CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    cfg_state_e         state_q, state_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [WBIT_W-1:0]  wbit_q, wbit_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               last_q, last_d;
    logic               len_err_q, len_err_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_reset_q, cfg_reset_d;
    logic               cbit_q, cbit_d;
    logic               start_s, lo_end_s, hi_end_s, hs_s;

    assign hs_s = in_valid && in_ready_q;

    ycell_cfg_strobe #(.CNT_W(STROBE_CNT_W)) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .lo_w    (STROBE_CNT_W'(STROBE_LO)),
        .hi_w    (STROBE_CNT_W'(STROBE_HI)),
        .confclk (confclk),
        .lo_end  (lo_end_s),
        .hi_end  (hi_end_s)
    );

    // Main sequencing: clear, per-word load, per-bit strobe, drain of surplus words.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        shreg_d   = shreg_q;
        wbit_d    = wbit_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        len_err_d = len_err_q;
        start_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {CLR_W{1'b0}};
                    len_err_d = 1'b0;
                    bit_cnt_d = {BIT_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    state_d   = ST_LOAD;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    shreg_d = in_data;
                    wbit_d  = {WBIT_W{1'b0}};
                    last_d  = in_last;
                    state_d = ST_SHIFT_LO;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SHIFT_LO: begin
                if (lo_end_s) begin
                    state_d = ST_SHIFT_HI;
                end else begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (hi_end_s) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    wbit_d    = wbit_q + WBIT_W'(1);
                    shreg_d   = shreg_q >> 1'b1;
                    if (bit_cnt_d == BIT_W'(CHAIN_LEN)) begin
                        // Chain full: leftover bits of this word are dropped silently.
                        if (last_q) begin
                            state_d   = ST_DONE;
                        end else begin
                            len_err_d = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else if (wbit_d == WBIT_W'(WORD_W)) begin
                        if (last_q) begin
                            len_err_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            state_d   = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_SHIFT_LO;
                        start_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_DRAIN: begin
                if (hs_s && in_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state; cbit only moves on entry to a low phase.
    always_comb begin
        in_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        case (state_d)
            ST_IDLE: cfg_reset_d = cfg_reset_q;
            ST_DONE: cfg_reset_d = 1'b0;
            default: cfg_reset_d = 1'b1;
        endcase
        if ((state_d == ST_SHIFT_LO) && (state_q != ST_SHIFT_LO)) begin
            cbit_d = shreg_d[0];
        end else begin
            cbit_d = cbit_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= {CLR_W{1'b0}};
            shreg_q     <= {WORD_W{1'b0}};
            wbit_q      <= {WBIT_W{1'b0}};
            bit_cnt_q   <= {BIT_W{1'b0}};
            last_q      <= 1'b0;
            len_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_reset_q <= 1'b1;
            cbit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            shreg_q     <= shreg_d;
            wbit_q      <= wbit_d;
            bit_cnt_q   <= bit_cnt_d;
            last_q      <= last_d;
            len_err_q   <= len_err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_reset_q <= cfg_reset_d;
            cbit_q      <= cbit_d;
        end
    end

`ifdef YCELL_CFG_READBACK_EN
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [MM_W-1:0]      mm_q, mm_d;

    // The tail bit leaving the chain at each rise is the previous image's bit at the same index.
    always_comb begin
        shadow_d = shadow_q;
        mm_d     = mm_q;
        if ((state_q == ST_IDLE) && in_valid) begin
            mm_d = {MM_W{1'b0}};
        end else if ((state_q == ST_SHIFT_LO) && lo_end_s) begin
            if (cbit_tail != shadow_q[bit_cnt_q]) begin
                mm_d = sat_inc(mm_q);
            end else begin
                mm_d = mm_q;
            end
            shadow_d[bit_cnt_q] = cbit_q;
        end else begin
            mm_d = mm_q;
        end
    end

    // Shadow image and mismatch counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {CHAIN_LEN{1'b0}};
            mm_q     <= {MM_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            mm_q     <= mm_d;
        end
    end

    assign mismatch_cnt = mm_q;
`else
    logic unused_tail;
    assign unused_tail  = cbit_tail;
    assign mismatch_cnt = {MM_W{1'b0}};
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;
    assign cfg_reset = cfg_reset_q;
    assign cbit      = cbit_q;

endmodule

// File: tb/tb_ycell_cfg_driver.sv
// Scoreboard bench for ycell_cfg_driver with a 12-bit chain model on confclk/cbit.
// Readback expectations are exercised when YCELL_CFG_READBACK_EN is defined.
module tb_ycell_cfg_driver;

    localparam int L = 12;
    localparam int W = 4;

    typedef struct {
        bit len_err;
        bit chk_mm;
        int mm;
    } done_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         cfg_reset, confclk, cbit, cbit_tail, busy, done, len_err;
    logic [15:0]  mismatch_cnt;

    logic [L-1:0] chain = '0;
    bit           exp_bits[$];
    done_t        exp_done[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           rise_cnt = 0;

`ifdef YCELL_CFG_READBACK_EN
    localparam bit DEF_CHK = 1'b0;
`else
    localparam bit DEF_CHK = 1'b1;
`endif

    always #5 clk = ~clk;

    ycell_cfg_driver #(
        .CHAIN_LEN(L), .WORD_W(W), .STROBE_LO(2), .STROBE_HI(2), .CLR_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .cfg_reset(cfg_reset),
        .confclk(confclk), .cbit(cbit), .cbit_tail(cbit_tail), .busy(busy),
        .done(done), .len_err(len_err), .mismatch_cnt(mismatch_cnt)
    );

    // Model of the cell chain: shifts on each confclk rise, tail comes out of the far end.
    always @(posedge confclk) chain <= {chain[L-2:0], cbit};
    assign cbit_tail = chain[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: bits go LSB-first across words, truncated at the chain length; the image
    // is correct only when the chain fills up inside the word marked last.
    task automatic expect_image(input logic [W-1:0] words[$], input bit chk_mm, input int mm);
        int    n     = words.size();
        int    total = n * W;
        int    nb    = (total < L) ? total : L;
        done_t d;
        for (int i = 0; i < nb; i++) begin
            logic [W-1:0] w = words[i / W];
            exp_bits.push_back(w[i % W]);
        end
        d.len_err = !(((n - 1) * W < L) && (L <= total));
        d.chk_mm  = chk_mm;
        d.mm      = mm;
        exp_done.push_back(d);
    endtask

    // Monitor: pops one expected bit per confclk rise and one result per done pulse.
    initial begin
        bit    prev_cc = 1'b0;
        bit    rise_cbit = 1'b0;
        done_t d;
        forever begin
            @(negedge clk);
            if (confclk === 1'b1 && !prev_cc) begin
                rise_cnt++;
                rise_cbit = cbit;
                if (exp_bits.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                else check("cbit_at_rise", {31'd0, cbit}, {31'd0, exp_bits.pop_front()});
            end else if (confclk === 1'b1) begin
                check("cbit_hold", {31'd0, cbit}, {31'd0, rise_cbit});
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = exp_done.pop_front();
                    check("len_err", {31'd0, len_err}, {31'd0, d.len_err});
                    check("cfg_reset_at_done", {31'd0, cfg_reset}, 32'd0);
                    if (d.chk_mm) check("mismatch_cnt", {16'd0, mismatch_cnt}, d.mm);
                end
            end
            prev_cc = (confclk === 1'b1);
        end
    end

    task automatic send_word(input logic [W-1:0] d, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("handshake", {31'd0, (t < 300)}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stall10();
        int t = 0;
        int highs = 0;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (confclk !== 1'b0) highs++;
        end
        check("stall_confclk", highs, 32'd0);
    endtask

    task automatic send_image(input logic [W-1:0] words[$], input int stall_at,
                              input bit chk_mm, input int mm);
        int t = 0;
        expect_image(words, chk_mm, mm);
        for (int i = 0; i < words.size(); i++) begin
            if (i == stall_at) stall10();
            send_word(words[i], i == words.size() - 1);
        end
        while (exp_done.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", exp_done.size(), 32'd0);
        @(negedge clk);
        check("cfg_reset_after_done", {31'd0, cfg_reset}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("bits_consumed", exp_bits.size(), 32'd0);
    endtask

    initial begin
        logic [W-1:0] img[$];
        int           target;
        int           t;
        int           n;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_confclk", {31'd0, confclk}, 32'd0);
        check("rst_cbit", {31'd0, cbit}, 32'd0);
        check("rst_cfg_reset", {31'd0, cfg_reset}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        check("rst_mismatch", {16'd0, mismatch_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef YCELL_CFG_READBACK_EN
        img = '{4'hA, 4'h5, 4'h3};
        send_image(img, -1, 1'b1, 0);
        send_image(img, -1, 1'b1, 0);
        img = '{4'h0, 4'h0, 4'h0};
        send_image(img, -1, 1'b1, 6);
`endif

        img = '{4'hA, 4'h5, 4'h3};
        send_image(img, -1, DEF_CHK, 0);
        img = '{4'hF, 4'hF};
        send_image(img, -1, DEF_CHK, 0);
        img = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        send_image(img, -1, DEF_CHK, 0);
        img = '{4'hA, 4'h5, 4'h3};
        send_image(img, 2, DEF_CHK, 0);

        // Abort with reset on the 5th strobe rise of an image.
        img = '{4'hA, 4'h5, 4'h3};
        expect_image(img, 1'b0, 0);
        target = rise_cnt + 5;
        send_word(4'hA, 1'b0);
        send_word(4'h5, 1'b0);
        t = 0;
        while (rise_cnt < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("abort_rise_reached", {31'd0, (t < 300)}, 32'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_confclk", {31'd0, confclk}, 32'd0);
        check("abort_cfg_reset", {31'd0, cfg_reset}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        exp_bits.delete();
        exp_done.delete();
        repeat (4) @(negedge clk);
        img = '{4'hA, 4'h5, 4'h3};
        send_image(img, -1, DEF_CHK, 0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 5);
            img = {};
            for (int i = 0; i < n; i++) img.push_back(W'($urandom_range(0, 15)));
            send_image(img, $urandom_range(1, n), DEF_CHK, 0);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ycell_cfg_driver.md
Name: ycell_cfg_driver

Overview:
Drives the serial configuration chain of a column of ycells, which is a daisy-chain of reset/confclk/cbitin→cbitout. It accepts configuration words over a valid/ready stream and serializes them LSB-first onto the chain's cbitin. It generates confclk strobes with programmable high/low widths and holds the array in reset while loading. It is the transmitting end of the cell configuration interface and replaces hand-written vector strobing in system-level benches and the loader in the fabric top.

Parameters:
CHAIN_LEN, 48, total configuration bits in the chain (cells × bits per cell).
WORD_W, 8, input word width.
STROBE_LO, 2, clk cycles confclk is low per bit; data setup time (≥1).
STROBE_HI, 2, clk cycles confclk is high per bit; data hold time (≥1).
CLR_CYCLES, 4, clk cycles cfg_reset is asserted before the first strobe.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  word available
in_ready  out  1  word accepted when in_valid&in_ready
in_data  in  WORD_W  config bits, bit 0 shifted first
in_last  in  1  marks final word of an image
cfg_reset  out  1  to chain reset
confclk  out  1  to chain confclk
cbit  out  1  to cbitin of first cell
cbit_tail  in  1  from cbitout of last cell (used only with readback)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at image end
len_err  out  1  sticky; image length ≠ CHAIN_LEN
mismatch_cnt  out  16  readback mismatches (0 without feature)

Behaviour:
- Reset values: in_ready=0, confclk=0, cbit=0, cfg_reset=1, busy=0, done=0, len_err=0, mismatch_cnt=0, bit_cnt=0, state=IDLE.
- States: IDLE, CLEAR, LOAD, SHIFT_LO, SHIFT_HI, DRAIN, DONE.
- IDLE: cfg_reset=0 after the first image; in_ready=0. On in_valid → CLEAR. Entry to CLEAR clears len_err, bit_cnt and mismatch_cnt. The word is not consumed in IDLE.
- CLEAR: cfg_reset=1 for CLR_CYCLES cycles → LOAD.
- LOAD: in_ready=1 and confclk=0. On handshake: latch the word into the shift register, set wbit=0, record in_last → SHIFT_LO.
- SHIFT_LO: cbit=shreg[0] stable; confclk=0 for STROBE_LO cycles → SHIFT_HI.
- SHIFT_HI: confclk=1 for STROBE_HI cycles. cbit is held. On exit: bit_cnt++, wbit++, shreg>>=1.
  - bit_cnt==CHAIN_LEN: go to DONE if the word had in_last; otherwise set len_err and go to DRAIN.
  - Otherwise, wbit==WORD_W: go to DONE if in_last, with len_err=1 because the image is short; otherwise go to LOAD.
  - Otherwise → SHIFT_LO.
- Unused high bits of the last word are discarded when CHAIN_LEN is reached mid-word; no error if that word has in_last.
- DRAIN: in_ready=1, no strobes; discard words until a handshake with in_last → DONE.
- DONE: done=1 for one cycle, cfg_reset→0 in the same cycle → IDLE.
- cfg_reset stays 1 from CLEAR through DONE-1.
- Latency: handshake to first confclk rise = STROBE_LO cycles. Per bit = STROBE_LO+STROBE_HI. Full image of 48 bits at 2/2 = 192 + CLR_CYCLES + per-word LOAD cycles (1 each).
- confclk and cbit are registered outputs, glitch-free. cbit never changes while confclk=1.
- Synchronous reset mid-image: abort immediately to reset values. The chain keeps partial contents with cfg_reset=1. No done pulse.
- in_valid dropping mid-image: wait in LOAD with confclk=0, unbounded.

Optional Feature:
Macro YCELL_CFG_READBACK_EN.
- With the macro: a CHAIN_LEN-bit shadow holds the previously loaded image. On each SHIFT_LO→SHIFT_HI transition, cbit_tail is sampled and compared with the shadow bit that is exiting the chain, indexed by bit_cnt. Each mismatch increments mismatch_cnt, saturating at 0xFFFF. The shadow is updated with the bit shifted in. The first image after reset compares against an all-zero shadow.
- Without the macro: no shadow register; mismatch_cnt tied to 0; cbit_tail unused.

Decomposition:
- Package ycell_cfg_pkg:
  - state enum type;
  - default constants CHAIN_LEN_DEF=48, WORD_W_DEF=8, STROBE_DEF=2, CLR_DEF=4;
  - mismatch counter width 16.
- Sub-module ycell_cfg_strobe: phase counter with inputs start, lo/hi widths; outputs confclk, lo_end, hi_end. The FSM in ycell_cfg_driver uses it for both SHIFT phases.

Test Plan:
- All tests use CHAIN_LEN=12, WORD_W=4, STROBE 2/2, CLR 4.
- Exact image: words 0xA, 0x5, 0x3 (last) → 12 confclk pulses; cbit per rise = 0,1,0,1,1,0,1,0,1,1,0,0; done once; len_err=0; cfg_reset low after done.
- Short image: 0xF, 0xF (last) → 8 pulses, done, len_err=1.
- Long image: 0x1, 0x2, 0x3, 0x4, 0x5 (last) → 12 pulses; 0x4 and 0x5 accepted in DRAIN with no pulses; len_err=1; done.
- Stall: in_valid low for 10 cycles between words 2 and 3 → confclk stays 0; bit sequence identical to the exact-image test.
- Reset asserted at the 5th confclk rise → next cycle confclk=0, cfg_reset=1, busy=0, no done; a new image then loads normally.
- With YCELL_CFG_READBACK_EN, bench models 12-bit chain: load 0xA,0x5,0x3, then same image → mismatch_cnt=0; then 0x0,0x0,0x0 → mismatch_cnt=6.
